// File: rtl/ycr1_tapc_pkg.sv
// Shared definitions for the JTAG TAP controller: state encoding, IR geometry,
// opcodes and the IDCODE value returned by the IDCODE data register.
package ycr1_tapc_pkg;

   localparam int unsigned YCR1_TAP_IR_WIDTH     = 5;
   localparam logic [4:0]  YCR1_TAP_IR_IDCODE    = 5'h01;
   localparam logic [4:0]  YCR1_TAP_IR_DTMCS     = 5'h10;
   localparam logic [4:0]  YCR1_TAP_IR_DMI       = 5'h11;
   localparam logic [4:0]  YCR1_TAP_IR_BYPASS    = 5'h1F;
   localparam logic [31:0] YCR1_TAP_IDCODE_VALUE = 32'hDEB1_1001;

   // One-hot so every state decode is a single flop bit and cannot glitch.
   typedef enum logic [15:0] {
      YCR1_TAP_STATE_RESET     = 16'h0001,
      YCR1_TAP_STATE_IDLE      = 16'h0002,
      YCR1_TAP_STATE_DR_SEL    = 16'h0004,
      YCR1_TAP_STATE_DR_CAP    = 16'h0008,
      YCR1_TAP_STATE_DR_SHIFT  = 16'h0010,
      YCR1_TAP_STATE_DR_EXIT1  = 16'h0020,
      YCR1_TAP_STATE_DR_PAUSE  = 16'h0040,
      YCR1_TAP_STATE_DR_EXIT2  = 16'h0080,
      YCR1_TAP_STATE_DR_UPDATE = 16'h0100,
      YCR1_TAP_STATE_IR_SEL    = 16'h0200,
      YCR1_TAP_STATE_IR_CAP    = 16'h0400,
      YCR1_TAP_STATE_IR_SHIFT  = 16'h0800,
      YCR1_TAP_STATE_IR_EXIT1  = 16'h1000,
      YCR1_TAP_STATE_IR_PAUSE  = 16'h2000,
      YCR1_TAP_STATE_IR_EXIT2  = 16'h4000,
      YCR1_TAP_STATE_IR_UPDATE = 16'h8000
   } type_ycr1_tap_state_e;

endpackage : ycr1_tapc_pkg

// File: rtl/ycr1_tapc_fsm.sv
// IEEE 1149.1 TAP state machine: state register, TMS-driven next state and
// the per-state strobes used by the IR path and the data registers.
module ycr1_tapc_fsm
   import ycr1_tapc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic tms,
   output logic tlr_o,
   output logic capture_ir_o,
   output logic shift_ir_o,
   output logic update_ir_o,
   output logic capture_dr_o,
   output logic shift_dr_o,
   output logic update_dr_o
);

   type_ycr1_tap_state_e state_q;
   type_ycr1_tap_state_e state_d;

   // State register; TRST forces Test-Logic-Reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= YCR1_TAP_STATE_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state per the 1149.1 transition graph
   always_comb begin
      state_d = state_q;
      case (state_q)
         YCR1_TAP_STATE_RESET     : state_d = tms ? YCR1_TAP_STATE_RESET     : YCR1_TAP_STATE_IDLE;
         YCR1_TAP_STATE_IDLE      : state_d = tms ? YCR1_TAP_STATE_DR_SEL    : YCR1_TAP_STATE_IDLE;
         YCR1_TAP_STATE_DR_SEL    : state_d = tms ? YCR1_TAP_STATE_IR_SEL    : YCR1_TAP_STATE_DR_CAP;
         YCR1_TAP_STATE_DR_CAP    : state_d = tms ? YCR1_TAP_STATE_DR_EXIT1  : YCR1_TAP_STATE_DR_SHIFT;
         YCR1_TAP_STATE_DR_SHIFT  : state_d = tms ? YCR1_TAP_STATE_DR_EXIT1  : YCR1_TAP_STATE_DR_SHIFT;
         YCR1_TAP_STATE_DR_EXIT1  : state_d = tms ? YCR1_TAP_STATE_DR_UPDATE : YCR1_TAP_STATE_DR_PAUSE;
         YCR1_TAP_STATE_DR_PAUSE  : state_d = tms ? YCR1_TAP_STATE_DR_EXIT2  : YCR1_TAP_STATE_DR_PAUSE;
         YCR1_TAP_STATE_DR_EXIT2  : state_d = tms ? YCR1_TAP_STATE_DR_UPDATE : YCR1_TAP_STATE_DR_SHIFT;
         YCR1_TAP_STATE_DR_UPDATE : state_d = tms ? YCR1_TAP_STATE_DR_SEL    : YCR1_TAP_STATE_IDLE;
         YCR1_TAP_STATE_IR_SEL    : state_d = tms ? YCR1_TAP_STATE_RESET     : YCR1_TAP_STATE_IR_CAP;
         YCR1_TAP_STATE_IR_CAP    : state_d = tms ? YCR1_TAP_STATE_IR_EXIT1  : YCR1_TAP_STATE_IR_SHIFT;
         YCR1_TAP_STATE_IR_SHIFT  : state_d = tms ? YCR1_TAP_STATE_IR_EXIT1  : YCR1_TAP_STATE_IR_SHIFT;
         YCR1_TAP_STATE_IR_EXIT1  : state_d = tms ? YCR1_TAP_STATE_IR_UPDATE : YCR1_TAP_STATE_IR_PAUSE;
         YCR1_TAP_STATE_IR_PAUSE  : state_d = tms ? YCR1_TAP_STATE_IR_EXIT2  : YCR1_TAP_STATE_IR_PAUSE;
         YCR1_TAP_STATE_IR_EXIT2  : state_d = tms ? YCR1_TAP_STATE_IR_UPDATE : YCR1_TAP_STATE_IR_SHIFT;
         YCR1_TAP_STATE_IR_UPDATE : state_d = tms ? YCR1_TAP_STATE_DR_SEL    : YCR1_TAP_STATE_IDLE;
         default                  : state_d = YCR1_TAP_STATE_RESET;
      endcase
   end

   assign tlr_o        = (state_q == YCR1_TAP_STATE_RESET);
   assign capture_ir_o = (state_q == YCR1_TAP_STATE_IR_CAP);
   assign shift_ir_o   = (state_q == YCR1_TAP_STATE_IR_SHIFT);
   assign update_ir_o  = (state_q == YCR1_TAP_STATE_IR_UPDATE);
   assign capture_dr_o = (state_q == YCR1_TAP_STATE_DR_CAP);
   assign shift_dr_o   = (state_q == YCR1_TAP_STATE_DR_SHIFT);
   assign update_dr_o  = (state_q == YCR1_TAP_STATE_DR_UPDATE);

endmodule : ycr1_tapc_fsm

// File: rtl/ycr1_tapc_ctrl.sv
// TAP controller front end: TAP FSM, instruction register and decode, BYPASS
// register and the falling-edge TDO mux feeding the debug data registers.
module ycr1_tapc_ctrl
   import ycr1_tapc_pkg::*;
#(
   parameter int unsigned                YCR1_IR_WIDTH  = YCR1_TAP_IR_WIDTH,
   parameter logic [YCR1_IR_WIDTH-1:0]   YCR1_IR_IDCODE = YCR1_TAP_IR_IDCODE,
   parameter logic [YCR1_IR_WIDTH-1:0]   YCR1_IR_DTMCS  = YCR1_TAP_IR_DTMCS,
   parameter logic [YCR1_IR_WIDTH-1:0]   YCR1_IR_DMI    = YCR1_TAP_IR_DMI,
   parameter logic [YCR1_IR_WIDTH-1:0]   YCR1_IR_BYPASS = YCR1_TAP_IR_BYPASS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tms,
   input  logic tdi,
   output logic tdo,
   output logic tdo_en,
   output logic rst_n_sync,
   output logic dr_sel_idcode,
   output logic dr_sel_dtmcs,
   output logic dr_sel_dmi,
   output logic fsm_dr_capture,
   output logic fsm_dr_shift,
   output logic fsm_dr_update,
   output logic dr_din_serial,
   input  logic dout_idcode,
   input  logic dout_dtmcs,
   input  logic dout_dmi
);

   localparam logic [YCR1_IR_WIDTH-1:0] IR_CAPTURE = {{(YCR1_IR_WIDTH-2){1'b0}}, 2'b01};

   logic                     tlr;
   logic                     capture_ir;
   logic                     shift_ir;
   logic                     update_ir;
   logic [YCR1_IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
   logic [YCR1_IR_WIDTH-1:0] ir_q, ir_d;
   logic                     bypass_q, bypass_d;
   logic                     bypass_sel;
   logic                     tdo_q, tdo_d;
   logic                     tdo_en_q, tdo_en_d;

   ycr1_tapc_fsm u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .tms          (tms),
      .tlr_o        (tlr),
      .capture_ir_o (capture_ir),
      .shift_ir_o   (shift_ir),
      .update_ir_o  (update_ir),
      .capture_dr_o (fsm_dr_capture),
      .shift_dr_o   (fsm_dr_shift),
      .update_dr_o  (fsm_dr_update)
   );

   // IR shift stage, active IR and BYPASS next values
   always_comb begin
      ir_shift_d = ir_shift_q;
      ir_d       = ir_q;
      bypass_d   = bypass_q;
      if (capture_ir) begin
         ir_shift_d = IR_CAPTURE;
      end else if (shift_ir) begin
         ir_shift_d = {tdi, ir_shift_q[YCR1_IR_WIDTH-1:1]};
      end else begin
         ir_shift_d = ir_shift_q;
      end
      if (tlr) begin
         ir_d = YCR1_IR_IDCODE;
      end else if (update_ir) begin
         ir_d = ir_shift_q;
      end else begin
         ir_d = ir_q;
      end
      if (fsm_dr_capture) begin
         bypass_d = 1'b0;
      end else if (fsm_dr_shift && bypass_sel) begin
         bypass_d = tdi;
      end else begin
         bypass_d = bypass_q;
      end
   end

   // Rising-edge IR and BYPASS state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_shift_q <= '0;
         ir_q       <= YCR1_IR_IDCODE;
         bypass_q   <= 1'b0;
      end else begin
         ir_shift_q <= ir_shift_d;
         ir_q       <= ir_d;
         bypass_q   <= bypass_d;
      end
   end

   assign dr_sel_idcode = (ir_q == YCR1_IR_IDCODE);
   assign dr_sel_dtmcs  = (ir_q == YCR1_IR_DTMCS);
   assign dr_sel_dmi    = (ir_q == YCR1_IR_DMI);
   // BYPASS opcode and every unknown opcode fall through to the 1-bit register
   assign bypass_sel    = ~(dr_sel_idcode | dr_sel_dtmcs | dr_sel_dmi);
   assign rst_n_sync    = ~tlr;
   assign dr_din_serial = tdi;

   // TDO source selection from the current state
   always_comb begin
      tdo_d    = 1'b0;
      tdo_en_d = shift_ir | fsm_dr_shift;
      if (shift_ir) begin
         tdo_d = ir_shift_q[0];
      end else if (fsm_dr_shift) begin
         if (dr_sel_idcode) begin
            tdo_d = dout_idcode;
         end else if (dr_sel_dtmcs) begin
            tdo_d = dout_dtmcs;
         end else if (dr_sel_dmi) begin
            tdo_d = dout_dmi;
         end else begin
            tdo_d = bypass_q;
         end
      end else begin
         tdo_d = 1'b0;
      end
   end

   // Falling-edge TDO register gives the host half a cycle of hold
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign tdo    = tdo_q;
   assign tdo_en = tdo_en_q;

endmodule : ycr1_tapc_ctrl

// File: tb/tb_ycr1_tapc_ctrl.sv
// Directed self-checking bench for the TAP controller front end.
module tb_ycr1_tapc_ctrl;

   logic clk = 1'b0;
   logic rst_n, tms, tdi;
   logic tdo, tdo_en, rst_n_sync;
   logic dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi;
   logic fsm_dr_capture, fsm_dr_shift, fsm_dr_update;
   logic dr_din_serial;
   logic dout_idcode, dout_dtmcs, dout_dmi;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ycr1_tapc_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tms            (tms),
      .tdi            (tdi),
      .tdo            (tdo),
      .tdo_en         (tdo_en),
      .rst_n_sync     (rst_n_sync),
      .dr_sel_idcode  (dr_sel_idcode),
      .dr_sel_dtmcs   (dr_sel_dtmcs),
      .dr_sel_dmi     (dr_sel_dmi),
      .fsm_dr_capture (fsm_dr_capture),
      .fsm_dr_shift   (fsm_dr_shift),
      .fsm_dr_update  (fsm_dr_update),
      .dr_din_serial  (dr_din_serial),
      .dout_idcode    (dout_idcode),
      .dout_dtmcs     (dout_dtmcs),
      .dout_dmi       (dout_dmi)
   );

   task automatic step(input logic t_tms, input logic t_tdi);
      tms = t_tms;
      tdi = t_tdi;
      @(posedge clk);
      #1;
   endtask

   task automatic half();
      @(negedge clk);
      #1;
   endtask

   // From Run-Test/Idle: load opcode v, return to Run-Test/Idle
   task automatic load_ir(input logic [4:0] v);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(i == 4, v[i]);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tms = 1'b1;
      tdi = 1'b0;
      repeat (3) @(posedge clk);
      half();
      n_tests++;
      if ({rst_n_sync, dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_sel got %b exp 0100", {rst_n_sync, dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi});
      end
      rst_n = 1'b1;
      step(1'b1, 1'b0);
      half();
      n_tests++;
      if ({rst_n_sync, dr_sel_idcode, tdo_en, tdo} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_tlr got %b exp 0100", {rst_n_sync, dr_sel_idcode, tdo_en, tdo});
      end
      n_tests++;
      if ({fsm_dr_capture, fsm_dr_shift, fsm_dr_update} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_strobes got %b exp 000", {fsm_dr_capture, fsm_dr_shift, fsm_dr_update});
      end
      step(1'b0, 1'b1);
      n_tests++;
      if (rst_n_sync !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_rst_n_sync got %b exp 1", rst_n_sync);
      end
      n_tests++;
      if (dr_din_serial !== 1'b1) begin
         n_fail++;
         $display("FAIL din_serial got %b exp 1", dr_din_serial);
      end
   endtask

   task automatic test_ir_load();
      logic [4:0] v;
      logic [4:0] exp_tdo;
      v = 5'h10;
      exp_tdo = 5'b00001;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         half();
         n_tests++;
         if ({tdo_en, tdo} !== {1'b1, exp_tdo[i]}) begin
            n_fail++;
            $display("FAIL ir_tdo[%0d] got en/tdo %b%b exp 1%b", i, tdo_en, tdo, exp_tdo[i]);
         end
         step(i == 4, v[i]);
      end
      step(1'b1, 1'b0);
      n_tests++;
      if (dr_sel_idcode !== 1'b1) begin
         n_fail++;
         $display("FAIL ir_in_update got idcode sel %b exp 1", dr_sel_idcode);
      end
      step(1'b0, 1'b0);
      n_tests++;
      if ({dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi} !== 3'b010) begin
         n_fail++;
         $display("FAIL ir_dtmcs_sel got %b exp 010", {dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi});
      end
   endtask

   task automatic test_bypass();
      logic [3:0] din;
      logic [3:0] exp_tdo;
      din = 4'b1101;
      exp_tdo = 4'b1010;
      load_ir(5'h1F);
      n_tests++;
      if ({dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi} !== 3'b000) begin
         n_fail++;
         $display("FAIL bypass_sel got %b exp 000", {dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi});
      end
      dout_idcode = 1'b1;
      dout_dtmcs = 1'b1;
      dout_dmi = 1'b1;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         half();
         n_tests++;
         if (tdo !== exp_tdo[i]) begin
            n_fail++;
            $display("FAIL bypass_tdo[%0d] got %b exp %b", i, tdo, exp_tdo[i]);
         end
         step(i == 3, din[i]);
      end
      half();
      n_tests++;
      if ({tdo_en, tdo} !== 2'b00) begin
         n_fail++;
         $display("FAIL bypass_exit got en/tdo %b exp 00", {tdo_en, tdo});
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic test_dr_strobes();
      logic [6:0] tms_seq;
      logic [6:0] exp_cap, exp_sh, exp_upd;
      logic [2:0] dmi_pat;
      int n_cap, n_sh, n_upd, sh_idx;
      tms_seq = 7'b0110000;
      exp_cap = 7'b0000001;
      exp_sh  = 7'b0001110;
      exp_upd = 7'b0100000;
      dmi_pat = 3'b101;
      n_cap = 0;
      n_sh = 0;
      n_upd = 0;
      sh_idx = 0;
      load_ir(5'h11);
      n_tests++;
      if ({dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi} !== 3'b001) begin
         n_fail++;
         $display("FAIL dmi_sel got %b exp 001", {dr_sel_idcode, dr_sel_dtmcs, dr_sel_dmi});
      end
      step(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(tms_seq[i], 1'b0);
         n_tests++;
         if ({fsm_dr_capture, fsm_dr_shift, fsm_dr_update} !== {exp_cap[i], exp_sh[i], exp_upd[i]}) begin
            n_fail++;
            $display("FAIL dr_strobe[%0d] got %b exp %b", i, {fsm_dr_capture, fsm_dr_shift, fsm_dr_update},
                     {exp_cap[i], exp_sh[i], exp_upd[i]});
         end
         n_cap += int'(fsm_dr_capture);
         n_sh  += int'(fsm_dr_shift);
         n_upd += int'(fsm_dr_update);
         if (exp_sh[i]) begin
            dout_dmi = dmi_pat[sh_idx];
            dout_idcode = ~dmi_pat[sh_idx];
            dout_dtmcs = ~dmi_pat[sh_idx];
            half();
            n_tests++;
            if (tdo !== dmi_pat[sh_idx]) begin
               n_fail++;
               $display("FAIL dmi_tdo[%0d] got %b exp %b", sh_idx, tdo, dmi_pat[sh_idx]);
            end
            sh_idx++;
         end
      end
      n_tests++;
      if (n_cap != 1 || n_sh != 3 || n_upd != 1) begin
         n_fail++;
         $display("FAIL dr_counts got %0d/%0d/%0d exp 1/3/1", n_cap, n_sh, n_upd);
      end
   endtask

   task automatic test_tms_reset();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      n_tests++;
      if (fsm_dr_shift !== 1'b1) begin
         n_fail++;
         $display("FAIL tmsrst_shift got %b exp 1", fsm_dr_shift);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         n_tests++;
         if (rst_n_sync !== (i != 4)) begin
            n_fail++;
            $display("FAIL tmsrst_edge[%0d] rst_n_sync got %b exp %b", i, rst_n_sync, (i != 4));
         end
      end
      step(1'b1, 1'b0);
      n_tests++;
      if ({rst_n_sync, dr_sel_idcode, dr_sel_dmi} !== 3'b010) begin
         n_fail++;
         $display("FAIL tmsrst_ir got %b exp 010", {rst_n_sync, dr_sel_idcode, dr_sel_dmi});
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_async_reset_mid_shift();
      logic [4:0] v;
      v = 5'h11;
      load_ir(5'h10);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, v[i]);
      half();
      n_tests++;
      if ({tdo_en, dr_sel_dtmcs} !== 2'b11) begin
         n_fail++;
         $display("FAIL midshift_pre got %b exp 11", {tdo_en, dr_sel_dtmcs});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({tdo, tdo_en, rst_n_sync, dr_sel_idcode, dr_sel_dtmcs} !== 5'b00010) begin
         n_fail++;
         $display("FAIL midshift_rst got %b exp 00010", {tdo, tdo_en, rst_n_sync, dr_sel_idcode, dr_sel_dtmcs});
      end
      tms = 1'b1;
      half();
      #2;
      rst_n = 1'b1;
      step(1'b0, 1'b0);
      n_tests++;
      if ({rst_n_sync, dr_sel_idcode} !== 2'b11) begin
         n_fail++;
         $display("FAIL midshift_after got %b exp 11", {rst_n_sync, dr_sel_idcode});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tms = 1'b1;
      tdi = 1'b0;
      dout_idcode = 1'b0;
      dout_dtmcs = 1'b0;
      dout_dmi = 1'b0;
      test_reset();
      test_ir_load();
      test_bypass();
      test_dr_strobes();
      test_tms_reset();
      test_async_reset_mid_shift();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ycr1_tapc_ctrl
